// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fixup.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_val
);

  // Pass through or negate depending on the enable.
  always_comb begin
    o_val = i_en ? -i_val : i_val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers, plus MTHI/MTLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_acc;      // product high half / partial remainder
  logic [W-1:0]     r_sr;       // multiplier shifting out / quotient shifting in
  logic [W-1:0]     r_opnd;     // multiplicand / divisor magnitude
  logic             r_is_div, r_neg_res, r_neg_rem, r_div0, r_done;
  logic [W-1:0]     r_hi, r_lo;

  logic             w_busy, w_load, w_last, w_signed, w_muldiv, w_ge;
  logic [W-1:0]     w_abs_a, w_abs_b, w_diff, w_quot, w_rem;
  logic [W:0]       w_sum, w_shift;
  logic [2*W-1:0]   w_prod;

  assign w_muldiv = ~op[2];
  assign w_signed = ~op[0];
  assign w_last   = (r_cnt == CNT_W'(W - 1));

  // Multiply step: add multiplicand when multiplier LSB is set; carry lands in bit W.
  assign w_sum   = {1'b0, r_acc} + {1'b0, (r_sr[0] ? r_opnd : '0)};
  // Divide step: shift dividend MSB into the remainder, then trial-subtract.
  assign w_shift = {r_acc, r_sr[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd});
  // When the trial succeeds the true difference is below the divisor, so W bits hold it.
  assign w_diff  = w_shift[W-1:0] - r_opnd;

  muldiv_negate #(.WIDTH(W)) u_abs_a (
    .i_val(a), .i_en(w_signed & a[W-1]), .o_val(w_abs_a)
  );
  muldiv_negate #(.WIDTH(W)) u_abs_b (
    .i_val(b), .i_en(w_signed & b[W-1]), .o_val(w_abs_b)
  );
  muldiv_negate #(.WIDTH(2*W)) u_fix_prod (
    .i_val({r_acc, r_sr}), .i_en(r_neg_res), .o_val(w_prod)
  );
  muldiv_negate #(.WIDTH(W)) u_fix_quot (
    .i_val(r_sr), .i_en(r_neg_res), .o_val(w_quot)
  );
  muldiv_negate #(.WIDTH(W)) u_fix_rem (
    .i_val(r_acc), .i_en(r_neg_rem), .o_val(w_rem)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and busy decode; starts are only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_muldiv) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, iteration datapath, HI/LO writeback and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sr      <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= (r_state == ST_FIX);
      if (w_load) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_is_div  <= op[1];
        r_neg_res <= w_signed & (a[W-1] ^ b[W-1]);
        r_neg_rem <= w_signed & op[1] & a[W-1];
        r_div0    <= op[1] & (b == '0);
        // Dividend / multiplier goes to the shift register, the other operand stays fixed.
        if (op[1]) begin
          r_sr   <= w_abs_a;
          r_opnd <= w_abs_b;
        end else begin
          r_sr   <= w_abs_b;
          r_opnd <= w_abs_a;
        end
      end else if (r_state == ST_IDLE && start) begin
        if (op == OP_MTHI)      r_hi <= a;
        else if (op == OP_MTLO) r_lo <= a;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_acc <= w_ge ? w_diff : w_shift[W-1:0];
          r_sr  <= {r_sr[W-2:0], w_ge};
        end else begin
          r_acc <= w_sum[W:1];
          r_sr  <= {w_sum[0], r_sr[W-1:1]};
        end
      end else if (r_state == ST_FIX && !r_div0) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          {r_hi, r_lo} <= w_prod;
        end
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed self-checking bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [31:0] exp_hi, exp_lo;
  int          n_checks = 0;
  int          n_errors = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted operation on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'b000: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'b001: begin p = ux * uy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'b010: if (y != 0) begin
        q = sx / sy; r = sx % sy;
        exp_lo = q[31:0]; exp_hi = r[31:0];
      end
      3'b011: if (y != 0) begin
        p = ux / uy; exp_lo = p[31:0];
        p = ux % uy; exp_hi = p[31:0];
      end
      3'b100: exp_hi = x;
      3'b101: exp_lo = x;
      default: ;
    endcase
  endtask

  // Drive start for exactly one rising edge, then scramble the operand inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  // Called at start-edge+1; counts edges until done, optionally poking starts while busy.
  task automatic wait_done(input bit inject);
    int cycles, busy_cnt;
    cycles = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 60) begin
      if (inject && cycles == 5) begin
        start = 1'b1; op = OP_MTLO; a = $urandom;
      end else if (inject && cycles == 20) begin
        start = 1'b1; op = OP_DIVU; a = $urandom; b = $urandom_range(1, 9);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
      if (busy) busy_cnt++;
    end
    check("latency", 64'(cycles), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_at_done", {63'b0, busy}, 64'd0);
  endtask

  task automatic finish_op(input logic [2:0] o, input bit inject);
    if (!o[2]) begin
      wait_done(inject);
    end else begin
      check("nb_busy", {63'b0, busy}, 64'd0);
      check("nb_done", {63'b0, done}, 64'd0);
    end
    check("hi", {32'b0, hi}, {32'b0, exp_hi});
    check("lo", {32'b0, lo}, {32'b0, exp_lo});
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    issue(o, x, y);
    finish_op(o, 1'b0);
    if (!o[2]) begin
      @(posedge clk); #1;
      check("done_pulse", {63'b0, done}, 64'd0);
    end
  endtask

  task automatic run_dir(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo);
    run_op(o, x, y);
    check("dir_hi", {32'b0, hi}, {32'b0, ehi});
    check("dir_lo", {32'b0, lo}, {32'b0, elo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;

    run_dir(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_dir(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_dir(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_dir(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_dir(OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3);
    run_dir(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    run_op(OP_MTHI, 32'h1234_5678, 32'd0);
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    run_dir(OP_DIVU, 32'd100, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    run_dir(3'b110, 32'hDEAD_BEEF, 32'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    run_dir(3'b111, 32'hDEAD_BEEF, 32'd3, 32'h1234_5678, 32'h9ABC_DEF0);

    // Starts while busy are dropped; a start in the done cycle is taken.
    @(negedge clk);
    issue(OP_MULTU, 32'd123456, 32'd789);
    finish_op(OP_MULTU, 1'b1);
    check("ign_hi", {32'b0, hi}, 64'd0);
    check("ign_lo", {32'b0, lo}, 64'd97406784);
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    finish_op(OP_MULT, 1'b0);
    check("b2b_lo", {32'b0, lo}, {32'b0, 32'hFFFF_FFFA});
    @(posedge clk); #1;
    check("b2b_done_pulse", {63'b0, done}, 64'd0);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    issue(OP_MULT, 32'd1000, 32'd1000);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_hi", {32'b0, hi}, 64'd0);
    check("arst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    run_dir(OP_MULT, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'd256);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = pick();
      ry = pick();
      if (ro[1] && $urandom_range(0, 5) == 0) ry = 32'd0;
      run_op(ro, rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage, beside the ALU/shift datapath.
- Consumes the same rs/rt register operands the ALU receives and owns the architectural HI/LO registers.
- Implements MULT/MULTU/DIV/DIVU as a 32-iteration shift-add / restoring-divide engine, plus single-cycle MTHI/MTLO.
- Control stalls the pipeline while busy and reads hi/lo for MFHI/MFLO.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH; the counter is clog2(DATA_WIDTH) bits.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; op, a and b are sampled on the edge where start=1.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored (no-op).
- a  input  DATA_WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source).
- b  input  DATA_WIDTH  rt operand (multiplier/divisor).
- busy  output  1  engine running; pipeline must stall.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
  - Reset asserted mid-operation aborts the operation and discards the partial result.
- States: IDLE, RUN, FIX.
- IDLE:
  - start with op MUL/DIV on edge E0: latch |a|, |b| (magnitude only for signed ops), sign flags and the op kind; clear the accumulator; counter=0; go to RUN; busy=1 after E0.
  - start with MTHI/MTLO: hi<=a or lo<=a at E0; stay in IDLE; busy and done stay 0.
  - start with op 11x: no effect.
- RUN: one iteration per edge, E1..E32; counter increments; at counter=DATA_WIDTH-1 go to FIX.
  - Multiply: 64-bit {acc,mplr} shifted right 1 per iteration; acc += mcand when mplr LSB=1, with carry kept in the 33rd bit.
  - Divide: 64-bit {rem,quot} shifted left 1 per iteration; trial subtract rem-divisor; if non-negative, keep the difference and set quot LSB=1.
- FIX at E33:
  - Apply sign correction. Signed multiply: negate the 64-bit product if sign(a)^sign(b). Signed divide: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
  - Write hi=upper word / remainder and lo=lower word / quotient.
  - busy<=0, done<=1 for exactly one cycle; return to IDLE.
- Latency: MUL/DIV results are visible after edge E33, i.e. 33 cycles after the start edge.
- start while busy=1 is ignored, including MTHI/MTLO.
- start may be reasserted in the cycle done=1; it begins a new operation on that edge.
- Divide by zero (b=0, DIV or DIVU):
  - Full 33-cycle timing still runs and done still pulses.
  - hi/lo are NOT written and keep their prior values.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Operands a and b may change freely after the start edge; only the latched copies are used.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - state encodings ST_IDLE, ST_RUN, ST_FIX.
  - DATA_WIDTH default.
- Sub-module muldiv_negate: combinational conditional two's-complement negate (input, enable, output).
  - Parameterised width.
  - Reused for operand abs-value and the result fixup: 32-bit for operands, 64-bit for the product.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Preload via MTHI 0x12345678 / MTLO 0x9ABCDEF0 (each visible the next cycle, no busy) -> DIVU a=100 b=0 -> done after 33 cycles; hi/lo unchanged.
5. MULTU started, then MTLO and DIVU issued at cycles 5 and 20 -> both ignored; the MULTU result is correct; back-to-back start in the done cycle is accepted.
6. Assert reset at RUN iteration 10 -> busy=0, done=0, hi=lo=0 immediately (async); a new MULT after release completes correctly.
